// File: rtl/fetch_align.sv
// -----------------------------------------------------------------------------
// fetch_align
//   Aligns 16/32-bit RISC-V instructions out of 64-bit instruction SRAM lines.
//   One line is buffered. A halfword register keeps the top halfword of the
//   previous line so that a 32-bit instruction that straddles two lines can be
//   assembled. The aligned instruction is presented combinationally and is
//   also registered into the fe2de decode-stage payload.
//
// Ports
//   clk                 in   system clock (rising edge)
//   cpurst              in   synchronous active-high reset
//   pc[31:0]            in   current fetch PC
//   isram_rdata[63:0]   in   SRAM read line, 8-byte aligned
//   isram_cs_ff         in   isram_rdata valid this cycle
//   isram_adr_ff[28:0]  in   line address [31:3] of isram_rdata
//   fet_flush           in   fetch stall/flush from PC generator
//   branch_predict_err  in   redirect from decode
//   de_stall            in   decode stall, holds fe2de register
//   rv32_instr[31:0]    out  aligned instruction (combinational)
//   isrv16              out  rv32_instr is a compressed instruction
//   instr_avail         out  rv32_instr is complete for pc
//   fetch_misalign      out  pc[0] set
//   fe2de_valid/pc/instr/isrv16  out  registered decode-stage payload
//   fa_state[1:0]       out  FSM state (debug)
// -----------------------------------------------------------------------------
module fetch_align (
  input  logic        clk,
  input  logic        cpurst,
  input  logic [31:0] pc,
  input  logic [63:0] isram_rdata,
  input  logic        isram_cs_ff,
  input  logic [28:0] isram_adr_ff,
  input  logic        fet_flush,
  input  logic        branch_predict_err,
  input  logic        de_stall,
  output logic [31:0] rv32_instr,
  output logic        isrv16,
  output logic        instr_avail,
  output logic        fetch_misalign,
  output logic        fe2de_valid,
  output logic [31:0] fe2de_pc,
  output logic [31:0] fe2de_instr,
  output logic        fe2de_isrv16,
  output logic [1:0]  fa_state
);

  localparam logic [1:0]  EMPTY = 2'd0;
  localparam logic [1:0]  LINE  = 2'd1;
  localparam logic [1:0]  SPLIT = 2'd2;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  // Line buffer and previous-line upper halfword
  logic [63:0] line_q;
  logic [28:0] line_tag;
  logic        line_vld;
  logic [15:0] hw_q;
  logic [28:0] hw_tag;
  logic        hw_vld;

  always_ff @(posedge clk) begin
    if (cpurst) begin
      line_vld <= 1'b0;
      hw_vld   <= 1'b0;
    end else if (isram_cs_ff) begin
      line_q   <= isram_rdata;
      line_tag <= isram_adr_ff;
      line_vld <= 1'b1;
      // Save the top halfword of the line being replaced
      if (line_vld) begin
        hw_q   <= line_q[63:48];
        hw_tag <= line_tag;
        hw_vld <= 1'b1;
      end
    end
  end

  // Current line: fresh SRAM data takes precedence over the buffer
  logic [63:0] cur_data;
  logic [28:0] cur_tag;
  logic        cur_vld;
  logic [28:0] pc_tag;
  logic [28:0] pc_tag_nx;
  logic        cur_hit;
  logic        cur_hit_nx;
  logic        byp_hit;
  logic        hw_hit;

  assign cur_data   = isram_cs_ff ? isram_rdata  : line_q;
  assign cur_tag    = isram_cs_ff ? isram_adr_ff : line_tag;
  assign cur_vld    = isram_cs_ff | line_vld;
  assign pc_tag     = pc[31:3];
  assign pc_tag_nx  = pc_tag + 29'd1;   // wraps in 29 bits
  assign cur_hit    = cur_vld && (cur_tag == pc_tag);
  assign cur_hit_nx = cur_vld && (cur_tag == pc_tag_nx);
  // While the next line is arriving, the old line's top halfword is still in
  // line_q (it only reaches hw_q next cycle); forward it so the cross-line
  // instruction completes in the same cycle as the second line.
  assign byp_hit    = isram_cs_ff && line_vld && (line_tag == pc_tag);
  assign hw_hit     = hw_vld && (hw_tag == pc_tag);

  // Low halfword of a cross-line instruction
  logic [15:0] lo16;
  logic        lo_found;
  logic [15:0] hi16;

  always_comb begin
    lo16     = 16'h0000;
    lo_found = 1'b0;
    if (cur_hit) begin
      lo16     = cur_data[63:48];
      lo_found = 1'b1;
    end else if (byp_hit) begin
      lo16     = line_q[63:48];
      lo_found = 1'b1;
    end else if (hw_hit) begin
      lo16     = hw_q;
      lo_found = 1'b1;
    end
  end

  assign hi16 = cur_hit_nx ? cur_data[15:0] : 16'h0000;

  logic [31:0] raw_instr;
  logic        raw_avail;
  logic        lo_is32;

  assign lo_is32 = (lo16[1:0] == 2'b11);

  always_comb begin
    raw_instr = 32'h0000_0000;
    raw_avail = 1'b0;
    case (pc[2:1])
      2'd0: begin raw_instr = cur_data[31:0];  raw_avail = cur_hit; end
      2'd1: begin raw_instr = cur_data[47:16]; raw_avail = cur_hit; end
      2'd2: begin raw_instr = cur_data[63:32]; raw_avail = cur_hit; end
      default: begin
        raw_instr = {hi16, lo16};
        raw_avail = lo_found && (!lo_is32 || cur_hit_nx);
      end
    endcase
  end

  assign fetch_misalign = pc[0];

  always_comb begin
    rv32_instr  = NOP;
    isrv16      = 1'b0;
    instr_avail = 1'b0;
    if (raw_avail && !fetch_misalign) begin
      rv32_instr  = raw_instr;
      isrv16      = (raw_instr[1:0] != 2'b11);
      instr_avail = 1'b1;
    end
  end

  // FSM (tracking/debug; alignment itself is tag driven)
  logic [1:0] state_reg;
  logic [1:0] state_next;
  logic       split_cond;

  assign split_cond = (pc[2:1] == 2'd3) && lo_found && lo_is32 && !cur_hit_nx;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      EMPTY:   if (isram_cs_ff) state_next = LINE;
      LINE:    if (split_cond) state_next = SPLIT;
      SPLIT:   if (instr_avail || branch_predict_err) state_next = LINE;
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (cpurst) state_reg <= EMPTY;
    else        state_reg <= state_next;
  end

  assign fa_state = state_reg;

  // Decode-stage payload register
  always_ff @(posedge clk) begin
    if (cpurst) begin
      fe2de_valid  <= 1'b0;
      fe2de_pc     <= 32'h0000_0000;
      fe2de_instr  <= NOP;
      fe2de_isrv16 <= 1'b0;
    end else if (de_stall) begin
      fe2de_valid  <= fe2de_valid;
    end else if (branch_predict_err || fet_flush || !instr_avail || fetch_misalign) begin
      fe2de_valid  <= 1'b0;
      fe2de_pc     <= pc;
      fe2de_instr  <= NOP;
      fe2de_isrv16 <= 1'b0;
    end else begin
      fe2de_valid  <= 1'b1;
      fe2de_pc     <= pc;
      fe2de_instr  <= rv32_instr;
      fe2de_isrv16 <= isrv16;
    end
  end

endmodule

// File: tb/tb_fetch_align.sv
module tb_fetch_align;

  logic        clk = 1'b0;
  logic        cpurst;
  logic [31:0] pc;
  logic [63:0] isram_rdata;
  logic        isram_cs_ff;
  logic [28:0] isram_adr_ff;
  logic        fet_flush;
  logic        branch_predict_err;
  logic        de_stall;
  logic [31:0] rv32_instr;
  logic        isrv16;
  logic        instr_avail;
  logic        fetch_misalign;
  logic        fe2de_valid;
  logic [31:0] fe2de_pc;
  logic [31:0] fe2de_instr;
  logic        fe2de_isrv16;
  logic [1:0]  fa_state;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fetch_align dut (
    .clk(clk), .cpurst(cpurst), .pc(pc), .isram_rdata(isram_rdata),
    .isram_cs_ff(isram_cs_ff), .isram_adr_ff(isram_adr_ff), .fet_flush(fet_flush),
    .branch_predict_err(branch_predict_err), .de_stall(de_stall),
    .rv32_instr(rv32_instr), .isrv16(isrv16), .instr_avail(instr_avail),
    .fetch_misalign(fetch_misalign), .fe2de_valid(fe2de_valid), .fe2de_pc(fe2de_pc),
    .fe2de_instr(fe2de_instr), .fe2de_isrv16(fe2de_isrv16), .fa_state(fa_state)
  );

  // Advance one clock; inputs change 1 ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cpurst = 1'b0; pc = 32'h0; isram_rdata = 64'h0; isram_cs_ff = 1'b0;
    isram_adr_ff = 29'h0; fet_flush = 1'b0; branch_predict_err = 1'b0; de_stall = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    cpurst = 1'b1;
    tick();
    cpurst = 1'b0;
    #1;
    total++; if (fa_state !== 2'd0) begin bad++; $display("FAIL rst_state got=%0d exp=0", fa_state); end
    total++; if (fe2de_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0b exp=0", fe2de_valid); end
    total++; if (fe2de_pc !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h exp=0", fe2de_pc); end
    total++; if (fe2de_instr !== 32'h13) begin bad++; $display("FAIL rst_instr got=%h exp=13", fe2de_instr); end
    total++; if (fe2de_isrv16 !== 1'b0) begin bad++; $display("FAIL rst_isrv16 got=%0b exp=0", fe2de_isrv16); end
    total++; if (instr_avail !== 1'b0) begin bad++; $display("FAIL rst_avail got=%0b exp=0", instr_avail); end
    total++; if (rv32_instr !== 32'h13) begin bad++; $display("FAIL rst_rv32 got=%h exp=13", rv32_instr); end
    $display("test_reset done");
  endtask

  task automatic test_basic();
    idle();
    pc = 32'h100; isram_cs_ff = 1'b1; isram_adr_ff = 29'h20; isram_rdata = 64'h00B50533_00A00093;
    #1;
    total++; if (rv32_instr !== 32'h00A00093) begin bad++; $display("FAIL basic_rv32 got=%h exp=00a00093", rv32_instr); end
    total++; if (instr_avail !== 1'b1) begin bad++; $display("FAIL basic_avail got=%0b exp=1", instr_avail); end
    total++; if (isrv16 !== 1'b0) begin bad++; $display("FAIL basic_isrv16 got=%0b exp=0", isrv16); end
    tick();
    total++; if (fe2de_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%0b exp=1", fe2de_valid); end
    total++; if (fe2de_pc !== 32'h100) begin bad++; $display("FAIL basic_pc got=%h exp=100", fe2de_pc); end
    total++; if (fe2de_instr !== 32'h00A00093) begin bad++; $display("FAIL basic_fe_instr got=%h exp=00a00093", fe2de_instr); end
    total++; if (fa_state !== 2'd1) begin bad++; $display("FAIL basic_state got=%0d exp=1", fa_state); end
    // Reuse of the buffered line at the other offsets
    isram_cs_ff = 1'b0; pc = 32'h104;
    #1;
    total++; if (rv32_instr !== 32'h00B50533) begin bad++; $display("FAIL held_off2 got=%h exp=00b50533", rv32_instr); end
    pc = 32'h102;
    #1;
    total++; if (rv32_instr !== 32'h053300A0) begin bad++; $display("FAIL held_off1 got=%h exp=053300a0", rv32_instr); end
    pc = 32'h108;
    #1;
    total++; if (instr_avail !== 1'b0) begin bad++; $display("FAIL tag_miss got=%0b exp=0", instr_avail); end
    tick();
    $display("test_basic done");
  endtask

  task automatic test_split();
    idle();
    pc = 32'h106; isram_cs_ff = 1'b1; isram_adr_ff = 29'h20; isram_rdata = 64'h0513_0000_0000_0000;
    #1;
    total++; if (instr_avail !== 1'b0) begin bad++; $display("FAIL split_avail0 got=%0b exp=0", instr_avail); end
    total++; if (rv32_instr !== 32'h13) begin bad++; $display("FAIL split_rv32_0 got=%h exp=13", rv32_instr); end
    tick();
    total++; if (fa_state !== 2'd2) begin bad++; $display("FAIL split_state got=%0d exp=2", fa_state); end
    total++; if (fe2de_valid !== 1'b0) begin bad++; $display("FAIL split_valid0 got=%0b exp=0", fe2de_valid); end
    isram_adr_ff = 29'h21; isram_rdata = 64'h0000_0000_0000_00A5;
    #1;
    total++; if (rv32_instr !== 32'h00A50513) begin bad++; $display("FAIL split_rv32 got=%h exp=00a50513", rv32_instr); end
    total++; if (instr_avail !== 1'b1) begin bad++; $display("FAIL split_avail got=%0b exp=1", instr_avail); end
    tick();
    total++; if (fa_state !== 2'd1) begin bad++; $display("FAIL split_state2 got=%0d exp=1", fa_state); end
    total++; if (fe2de_instr !== 32'h00A50513) begin bad++; $display("FAIL split_fe_instr got=%h exp=00a50513", fe2de_instr); end
    total++; if (fe2de_pc !== 32'h106) begin bad++; $display("FAIL split_fe_pc got=%h exp=106", fe2de_pc); end
    // Line 0x21 now buffered; the low half must come from the saved halfword
    isram_cs_ff = 1'b0;
    #1;
    total++; if (rv32_instr !== 32'h00A50513) begin bad++; $display("FAIL hw_reuse got=%h exp=00a50513", rv32_instr); end
    tick();
    $display("test_split done");
  endtask

  task automatic test_rvc();
    idle();
    pc = 32'h106; isram_cs_ff = 1'b1; isram_adr_ff = 29'h20; isram_rdata = 64'h4505_0000_0000_0000;
    #1;
    total++; if (rv32_instr !== 32'h00004505) begin bad++; $display("FAIL rvc_rv32 got=%h exp=00004505", rv32_instr); end
    total++; if (isrv16 !== 1'b1) begin bad++; $display("FAIL rvc_isrv16 got=%0b exp=1", isrv16); end
    total++; if (instr_avail !== 1'b1) begin bad++; $display("FAIL rvc_avail got=%0b exp=1", instr_avail); end
    tick();
    total++; if (fe2de_isrv16 !== 1'b1) begin bad++; $display("FAIL rvc_fe_isrv16 got=%0b exp=1", fe2de_isrv16); end
    total++; if (fa_state !== 2'd1) begin bad++; $display("FAIL rvc_state got=%0d exp=1", fa_state); end
    $display("test_rvc done");
  endtask

  task automatic test_misalign();
    idle();
    pc = 32'h101;
    #1;
    total++; if (fetch_misalign !== 1'b1) begin bad++; $display("FAIL mis_flag got=%0b exp=1", fetch_misalign); end
    total++; if (rv32_instr !== 32'h13) begin bad++; $display("FAIL mis_rv32 got=%h exp=13", rv32_instr); end
    tick();
    total++; if (fe2de_valid !== 1'b0) begin bad++; $display("FAIL mis_valid got=%0b exp=0", fe2de_valid); end
    total++; if (fe2de_pc !== 32'h101) begin bad++; $display("FAIL mis_pc got=%h exp=101", fe2de_pc); end
    $display("test_misalign done");
  endtask

  task automatic test_flush();
    idle();
    pc = 32'h100; isram_cs_ff = 1'b1; isram_adr_ff = 29'h20; isram_rdata = 64'h0513_0000_00A0_0093;
    fet_flush = 1'b1;
    tick();
    total++; if (fe2de_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%0b exp=0", fe2de_valid); end
    total++; if (fe2de_instr !== 32'h13) begin bad++; $display("FAIL flush_instr got=%h exp=13", fe2de_instr); end
    $display("test_flush done");
  endtask

  task automatic test_bpe_stall();
    idle();
    // Valid instruction into fe2de, line 0x20 top half = 32-bit low half
    pc = 32'h100; isram_cs_ff = 1'b1; isram_adr_ff = 29'h20; isram_rdata = 64'h0513_0000_00A0_0093;
    tick();
    total++; if (fe2de_valid !== 1'b1) begin bad++; $display("FAIL bs_load got=%0b exp=1", fe2de_valid); end
    // Enter SPLIT while decode is stalled
    isram_cs_ff = 1'b0; pc = 32'h106; de_stall = 1'b1;
    tick();
    total++; if (fa_state !== 2'd2) begin bad++; $display("FAIL bs_split got=%0d exp=2", fa_state); end
    branch_predict_err = 1'b1;
    tick();
    total++; if (fa_state !== 2'd1) begin bad++; $display("FAIL bs_bpe_state got=%0d exp=1", fa_state); end
    total++; if (fe2de_valid !== 1'b1) begin bad++; $display("FAIL bs_hold_valid got=%0b exp=1", fe2de_valid); end
    total++; if (fe2de_pc !== 32'h100) begin bad++; $display("FAIL bs_hold_pc got=%h exp=100", fe2de_pc); end
    total++; if (fe2de_instr !== 32'h00A00093) begin bad++; $display("FAIL bs_hold_instr got=%h exp=00a00093", fe2de_instr); end
    // SPLIT again, then redirect without stall
    branch_predict_err = 1'b0; de_stall = 1'b0;
    tick();
    total++; if (fa_state !== 2'd2) begin bad++; $display("FAIL b_split got=%0d exp=2", fa_state); end
    branch_predict_err = 1'b1;
    tick();
    total++; if (fa_state !== 2'd1) begin bad++; $display("FAIL b_state got=%0d exp=1", fa_state); end
    total++; if (fe2de_valid !== 1'b0) begin bad++; $display("FAIL b_valid got=%0b exp=0", fe2de_valid); end
    $display("test_bpe_stall done");
  endtask

  task automatic test_reset_in_split();
    idle();
    pc = 32'h100; isram_cs_ff = 1'b1; isram_adr_ff = 29'h20; isram_rdata = 64'h0513_0000_00A0_0093;
    tick();
    isram_cs_ff = 1'b0; pc = 32'h106; de_stall = 1'b1;
    tick();
    total++; if (fa_state !== 2'd2) begin bad++; $display("FAIL rs_split got=%0d exp=2", fa_state); end
    cpurst = 1'b1;
    tick();
    cpurst = 1'b0; de_stall = 1'b0;
    #1;
    total++; if (fa_state !== 2'd0) begin bad++; $display("FAIL rs_state got=%0d exp=0", fa_state); end
    total++; if (fe2de_valid !== 1'b0) begin bad++; $display("FAIL rs_valid got=%0b exp=0", fe2de_valid); end
    total++; if (fe2de_pc !== 32'h0) begin bad++; $display("FAIL rs_pc got=%h exp=0", fe2de_pc); end
    total++; if (fe2de_instr !== 32'h13) begin bad++; $display("FAIL rs_instr got=%h exp=13", fe2de_instr); end
    // Held half and line are gone
    total++; if (instr_avail !== 1'b0) begin bad++; $display("FAIL rs_avail got=%0b exp=0", instr_avail); end
    pc = 32'h100;
    #1;
    total++; if (instr_avail !== 1'b0) begin bad++; $display("FAIL rs_line got=%0b exp=0", instr_avail); end
    tick();
    $display("test_reset_in_split done");
  endtask

  initial begin
    idle();
    #2;
    test_reset();
    test_basic();
    test_split();
    test_rvc();
    test_misalign();
    test_flush();
    test_bpe_stall();
    test_reset_in_split();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_align.md
FETCH_ALIGN -- requirements
Module: fetch_align

Interface
REQ-001 SHALL use one clock and a synchronous, active-high reset: clk rising edge; cpurst synchronous, active-high.
REQ-002 clk  in  1  system clock.
REQ-003 cpurst  in  1  synchronous active-high reset.
REQ-004 pc  in  32  current fetch PC from PC generator.
REQ-005 isram_rdata  in  64  instruction SRAM read line, 8-byte aligned.
REQ-006 isram_cs_ff  in  1  isram_rdata valid this cycle (read issued last cycle).
REQ-007 isram_adr_ff  in  29  line address [31:3] of isram_rdata.
REQ-008 fet_flush  in  1  fetch stall/flush from PC generator.
REQ-009 branch_predict_err  in  1  redirect from decode.
REQ-010 de_stall  in  1  decode stall; hold fe2de register.
REQ-011 rv32_instr  out  32  aligned instruction to mini decoder (combinational).
REQ-012 isrv16  out  1  rv32_instr[1:0]!=2'b11.
REQ-013 instr_avail  out  1  rv32_instr complete for pc.
REQ-014 fetch_misalign  out  1  pc[0]==1.
REQ-015 fe2de_valid, fe2de_pc[31:0], fe2de_instr[31:0], fe2de_isrv16  out  registered decode-stage payload.
REQ-016 fa_state  out  2  FSM state, debug.

Function
REQ-017 Line buffer line_q[63:0]/line_tag[31:3]/line_vld SHALL load isram_rdata/isram_adr_ff/1 on isram_cs_ff.
REQ-018 Current line cur = isram_cs_ff ? (isram_rdata, isram_adr_ff) : (line_q, line_tag); cur_vld = isram_cs_ff | line_vld.
REQ-019 On isram_cs_ff with line_vld, halfword register hw_q <= line_q[63:48], hw_tag <= line_tag, hw_vld <= 1 (captured before line overwrite).
REQ-020 pc[2:1] in {0,1,2}: instr = cur >> (16*pc[2:1]) bits [31:0]; avail = cur_vld & cur_tag==pc[31:3].
REQ-021 pc[2:1]==3: lo16 = cur[63:48] if cur_tag==pc[31:3], else hw_q if hw_vld & hw_tag==pc[31:3]; hi16 = cur[15:0] if cur_tag==pc[31:3]+1 (29-bit wrap).
REQ-022 pc[2:1]==3: avail = lo16 found & (lo16[1:0]!=2'b11 | hi16 found); instr = {hi16 or 16'h0, lo16}.
REQ-023 When !avail or fetch_misalign: rv32_instr = 32'h00000013, isrv16 = 0, instr_avail = 0.
REQ-024 FSM states: EMPTY(0) no line; LINE(1) line held; SPLIT(2) low half of 32-bit cross-line instruction held, upper awaited.
REQ-025 EMPTY->LINE on isram_cs_ff; LINE->SPLIT when pc[2:1]==3, lo16 found, lo16 32-bit, hi16 not found; SPLIT->LINE when avail or branch_predict_err; else hold.
REQ-026 fe2de register priority: cpurst > de_stall (hold all) > (branch_predict_err | fet_flush | !instr_avail | fetch_misalign: valid=0, instr=32'h13, isrv16=0, pc<=pc) > load (valid=1, pc, rv32_instr, isrv16).
REQ-027 Simultaneous de_stall and branch_predict_err: de_stall wins for fe2de; line/hw/FSM updates unaffected by de_stall.
REQ-028 Tags guard all reuse; no data invalidation except reset.
REQ-029 Latency: instruction in isram_rdata cycle N appears on rv32_instr cycle N, on fe2de cycle N+1.

Reset
REQ-030 cpurst SHALL clear line_vld, hw_vld, fe2de_valid, fe2de_isrv16, fe2de_pc=0, set fe2de_instr=32'h00000013, fa_state=EMPTY; reset mid-SPLIT abandons the held half.
REQ-031 First cycle after reset with no isram_cs_ff: instr_avail=0, rv32_instr=32'h13.

Verification
REQ-032 pc=0x100, isram_cs_ff=1, adr_ff=0x20, rdata=0x00B50533_00A00093 -> rv32_instr=0x00A00093, avail=1; next cycle fe2de_valid=1, fe2de_pc=0x100.
REQ-033 pc=0x106, line 0x20 rdata[63:48]=0x0513 (32-bit low half) -> avail=0, SPLIT; next cycle adr_ff=0x21 rdata[15:0]=0x00A5 -> rv32_instr=0x00A50513, state LINE.
REQ-034 pc=0x106, rdata[63:48]=0x4505 -> isrv16=1, rv32_instr=0x00004505, avail=1 without second line.
REQ-035 pc=0x101 -> fetch_misalign=1, rv32_instr=0x13, fe2de_valid=0 next cycle.
REQ-036 In SPLIT, branch_predict_err=1 -> state LINE, fe2de_valid=0; de_stall=1 at same time -> fe2de holds prior values.
REQ-037 cpurst asserted in SPLIT -> all REQ-030 values next cycle, fa_state=0.
